// File: rtl/switch_allocator_if.sv
// Switch-allocator bundle between the input-port buffers and the allocator.
//   request_i       : per-input switch request (sa_request_o of each input port)
//   out_port_i      : per-input requested output index
//   is_tail_i       : head-of-buffer flit is TAIL or HEADTAIL
//   is_head_i       : head-of-buffer flit is HEAD or HEADTAIL
//   downstream_on_i : per-output on/off from downstream (1 = may send)
//   grant_o         : per-input buffer read command (combinational)
//   xb_sel_o        : per-output registered crossbar input select
//   xb_valid_o      : per-output registered crossbar valid
//   error_o         : registered protocol-violation pulse
// slave = allocator side, master = input-port/downstream side.
interface switch_allocator_if #(
    parameter int unsigned PORT_NUM = 5
);
    localparam int unsigned SEL_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [PORT_NUM-1:0]               request_i;
    logic [PORT_NUM-1:0][SEL_SIZE-1:0] out_port_i;
    logic [PORT_NUM-1:0]               is_tail_i;
    logic [PORT_NUM-1:0]               is_head_i;
    logic [PORT_NUM-1:0]               downstream_on_i;
    logic [PORT_NUM-1:0]               grant_o;
    logic [PORT_NUM-1:0][SEL_SIZE-1:0] xb_sel_o;
    logic [PORT_NUM-1:0]               xb_valid_o;
    logic                              error_o;

    modport slave (
        input  request_i, out_port_i, is_tail_i, is_head_i, downstream_on_i,
        output grant_o, xb_sel_o, xb_valid_o, error_o
    );

    modport master (
        output request_i, out_port_i, is_tail_i, is_head_i, downstream_on_i,
        input  grant_o, xb_sel_o, xb_valid_o, error_o
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking.
//   clk : clock
//   rst : synchronous reset, active-low
//   sa  : allocator bundle (slave side): requests, destinations, flit type,
//         downstream on/off in; combinational grants, registered crossbar
//         select/valid and error pulse out.
// Each output is either IDLE (round-robin among head flits) or LOCKED to one
// input until that input's tail flit is granted.
module switch_allocator #(
    parameter int unsigned PORT_NUM = 5
) (
    input  logic                clk,
    input  logic                rst,
    switch_allocator_if.slave   sa
);
    localparam int unsigned SEL_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    state_e                            fsm_q [PORT_NUM];
    state_e                            fsm_d [PORT_NUM];
    logic [PORT_NUM-1:0][SEL_SIZE-1:0] owner_q, owner_d;
    logic [PORT_NUM-1:0][SEL_SIZE-1:0] rr_q, rr_d;
    logic [PORT_NUM-1:0][SEL_SIZE-1:0] sel_q, sel_d;
    logic [PORT_NUM-1:0]               valid_q, valid_d;
    logic                              err_q, err_d;
    logic [PORT_NUM-1:0]               grant_c;
    logic [PORT_NUM-1:0]               locked_in;
    logic [SEL_SIZE-1:0]               own;
    logic [SEL_SIZE-1:0]               cand;
    logic                              found;
    int unsigned                       idx;

    // Arbitration, lock tracking and crossbar next-state for every output.
    always_comb begin
        grant_c   = '0;
        valid_d   = '0;
        err_d     = 1'b0;
        sel_d     = sel_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        locked_in = '0;
        own       = '0;
        cand      = '0;
        found     = 1'b0;
        idx       = 0;
        for (int o = 0; o < int'(PORT_NUM); o++) begin
            fsm_d[o] = fsm_q[o];
        end

        // An input holding a lock may not win any other (idle) output.
        for (int o = 0; o < int'(PORT_NUM); o++) begin
            if (fsm_q[o] == S_LOCKED) begin
                locked_in[owner_q[o]] = 1'b1;
            end
        end

        for (int o = 0; o < int'(PORT_NUM); o++) begin
            own   = owner_q[o];
            found = 1'b0;
            cand  = '0;
            if (fsm_q[o] == S_LOCKED) begin
                if (sa.request_i[own]) begin
                    if (sa.out_port_i[own] != SEL_SIZE'(o)) begin
                        err_d = 1'b1;
                    end else if (sa.downstream_on_i[o]) begin
                        grant_c[own] = 1'b1;
                        valid_d[o]   = 1'b1;
                        sel_d[o]     = own;
                        if (sa.is_tail_i[own]) begin
                            fsm_d[o] = S_IDLE;
                        end
                    end
                end
            end else begin
                // First eligible input scanning from the round-robin pointer.
                for (int unsigned k = 0; k < PORT_NUM; k++) begin
                    idx = 32'(rr_q[o]) + k;
                    if (idx >= PORT_NUM) begin
                        idx = idx - PORT_NUM;
                    end
                    if (!found && sa.request_i[idx] && !locked_in[idx] &&
                        sa.out_port_i[idx] == SEL_SIZE'(o) && sa.downstream_on_i[o]) begin
                        found = 1'b1;
                        cand  = SEL_SIZE'(idx);
                    end
                end
                if (found) begin
                    if (sa.is_head_i[cand]) begin
                        grant_c[cand] = 1'b1;
                        valid_d[o]    = 1'b1;
                        sel_d[o]      = cand;
                        rr_d[o]       = (cand == SEL_SIZE'(PORT_NUM - 1)) ? '0 : cand + 1'b1;
                        if (!sa.is_tail_i[cand]) begin
                            fsm_d[o]   = S_LOCKED;
                            owner_d[o] = cand;
                        end
                    end else begin
                        // Body flit with no lock: protocol violation, not granted.
                        err_d = 1'b1;
                    end
                end
            end
        end

        if (!rst) begin
            grant_c = '0;
        end
    end

    // State and crossbar registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < int'(PORT_NUM); o++) begin
                fsm_q[o] <= S_IDLE;
            end
            owner_q <= '0;
            rr_q    <= '0;
            sel_q   <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int o = 0; o < int'(PORT_NUM); o++) begin
                fsm_q[o] <= fsm_d[o];
            end
            owner_q <= owner_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign sa.grant_o    = grant_c;
    assign sa.xb_sel_o   = sel_q;
    assign sa.xb_valid_o = valid_q;
    assign sa.error_o    = err_q;

endmodule
